// File: rtl/aes_round_ctrl_pkg.sv
// aes_pkg: shared AES controller types and constants.
package aes_pkg;
    localparam int AES_NR_128 = 10;
    localparam int RND_W = 4;
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_e;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: host handshake plus core-side sequencing strobes.
interface aes_round_ctrl_if
    import aes_pkg::*;
#(parameter int CNT_W = 16) ();
    logic             start;
    logic             ready;
    logic             accept;
    logic [RND_W-1:0] rndNo;
    logic             enbSB;
    logic             enbSR;
    logic             enbMC;
    logic             enbAR;
    logic             enbKS;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] blk_cnt;
    modport master (output start, input ready, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS, busy, done, blk_cnt);
    modport slave  (input start, output ready, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS, busy, done, blk_cnt);
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the iterative AES core, one round per clock.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR_128,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rstn,
    aes_round_ctrl_if.slave bus
);
    localparam logic [RND_W-1:0] LAST = RND_W'(NR - 1);
    state_e           state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? LOAD : IDLE;
                rnd_d   = '0;
            end
            LOAD: begin
                state_d = ROUND;
                rnd_d   = RND_W'(1);
            end
            ROUND: begin
                state_d = (rnd_q == LAST) ? FINAL : ROUND;
                rnd_d   = rnd_q + RND_W'(1);
            end
            FINAL: begin
                // a start here chains straight into the next LOAD
                state_d = bus.start ? LOAD : IDLE;
                rnd_d   = '0;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                rnd_d   = '0;
            end
        endcase
    end
    assign bus.ready   = (state_q == IDLE) || (state_q == FINAL);
    assign bus.accept  = (state_q == LOAD);
    assign bus.rndNo   = rnd_q;
    assign bus.enbSB   = (state_q == ROUND) || (state_q == FINAL);
    assign bus.enbSR   = (state_q == ROUND) || (state_q == FINAL);
    assign bus.enbMC   = (state_q == ROUND);
    assign bus.enbAR   = (state_q != IDLE);
    assign bus.enbKS   = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == FINAL);
    assign bus.blk_cnt = cnt_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: timeline model of the controller plus a behavioural AES core
// driven by the controller strobes, checked against the FIPS-197 C.1 vector.
module tb_aes_round_ctrl;
    import aes_pkg::*;
    localparam int NR = 10;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    aes_round_ctrl_if #(.CNT_W(16)) bus ();
    aes_round_ctrl_if #(.CNT_W(2))  bus2 ();
    assign bus2.start = bus.start;

    aes_round_ctrl #(.NR(NR), .CNT_W(16)) u_dut  (.clk(clk), .rstn(rstn), .bus(bus.slave));
    aes_round_ctrl #(.NR(NR), .CNT_W(2))  u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2.slave));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, ph = -1, ndone = 0;
    logic [15:0]  mcnt = '0;
    logic [127:0] st, kreg, ct;
    logic [7:0]   rc;
    logic         acc_s, ar_s, ks_s, mc_s;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: x^254 is the GF(2^8) inverse, then the affine map
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] r, b;
        logic [15:0] d;
        r = 8'h01; b = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gm(r, b);
            b = gm(b, b);
        end
        d = {r, r};
        return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [7:0] by(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] step(input logic [127:0] s, input logic [127:0] k, input logic mc);
        logic [127:0] t, o;
        logic [7:0] a0, a1, a2, a3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[127-8*(r+4*c) -: 8] = sb(by(s, r + 4*((c+r)%4)));
        o = t;
        if (mc)
            for (int c = 0; c < 4; c++) begin
                a0 = by(t, 4*c); a1 = by(t, 4*c+1); a2 = by(t, 4*c+2); a3 = by(t, 4*c+3);
                o[127-8*(4*c)   -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                o[127-8*(4*c+1) -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                o[127-8*(4*c+3) -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
        return o ^ k;
    endfunction

    function automatic logic [127:0] knext(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        w3 = k[31:0];
        t  = {sb(w3[23:16]) ^ rcon, sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        return {w0, w1, w2, w3 ^ w2};
    endfunction

    // expected outputs from ph = cycles since LOAD (-1 when idle)
    function automatic logic [127:0] expv(input int p, input logic [15:0] c);
        return 128'({p < 0 || p == NR, p == 0, 4'(p < 0 ? 0 : p), p >= 1, p >= 1,
                     p >= 1 && p < NR, p >= 0, p >= 0, p >= 0, p == NR, c});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            ph   <= -1;
            mcnt <= '0;
        end else if (ph < 0) ph <= bus.start ? 0 : -1;
        else if (ph == NR) begin
            ph   <= bus.start ? 0 : -1;
            mcnt <= mcnt + 16'd1;
        end else ph <= ph + 1;

    always @(negedge clk) {acc_s, ar_s, ks_s, mc_s} <= {bus.accept, bus.enbAR, bus.enbKS, bus.enbMC};

    always @(posedge clk)
        if (acc_s) begin
            st   <= PT ^ KEY;
            kreg <= knext(KEY, 8'h01);
            rc   <= 8'h02;
        end else if (ar_s) begin
            st <= step(st, kreg, mc_s);
            if (ks_s) begin
                kreg <= knext(kreg, rc);
                rc   <= xt(rc);
            end
        end

    always_comb ct = step(st, kreg, bus.enbMC);

    always @(negedge clk) begin
        chk("outputs", 128'({bus.ready, bus.accept, bus.rndNo, bus.enbSB, bus.enbSR, bus.enbMC,
                             bus.enbAR, bus.enbKS, bus.busy, bus.done, bus.blk_cnt}), expv(ph, mcnt));
        chk("dut2 done/cnt", 128'({bus2.done, bus2.blk_cnt}), 128'({ph == NR, mcnt[1:0]}));
        if (bus.done) begin
            ndone <= ndone + 1;
            chk("cipher", ct, CT);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++)
            if (bus.done) t = cyc;
            else tick();
        if (t < 0) chk("done timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_rnd(input logic [3:0] v);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++)
            if (bus.busy && bus.rndNo == v) hit = 1'b1;
            else tick();
        if (!hit) chk("round timeout", 128'(0), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, nd;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.start = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (20) tick();
        chk("idle ready/busy/cnt", 128'({bus.ready, bus.busy, bus.blk_cnt}), 128'({1'b1, 1'b0, 16'd0}));
        // single block
        bus.start = 1'b1;
        tick();
        t0 = cyc;
        bus.start = 1'b0;
        chk("load strobes", 128'({bus.accept, bus.rndNo, bus.enbSB, bus.enbMC, bus.enbAR, bus.enbKS}),
            128'({1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1}));
        wait_done(t1);
        chk("done cycle", 128'(t1 - t0 + 1), 128'(11));
        chk("final strobes", 128'({bus.rndNo, bus.enbSB, bus.enbSR, bus.enbMC, bus.enbAR, bus.enbKS}),
            128'({4'd10, 5'b11011}));
        chk("ct literal", ct, CT);
        tick();
        chk("single end", 128'({bus.ready, bus.busy, bus.blk_cnt}), 128'({1'b1, 1'b0, 16'd1}));
        // back-to-back, three blocks
        do_reset();
        bus.start = 1'b1;
        wait_done(t1);
        tick();
        chk("b2b load", 128'({bus.accept, bus.busy, bus.rndNo}), 128'({1'b1, 1'b1, 4'd0}));
        wait_done(t2);
        tick();
        bus.start = 1'b0;
        wait_done(t3);
        chk("b2b gap1", 128'(t2 - t1), 128'(11));
        chk("b2b gap2", 128'(t3 - t2), 128'(11));
        tick();
        chk("b2b end", 128'({bus.busy, bus.blk_cnt}), 128'({1'b0, 16'd3}));
        // start while busy is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rnd(4'd5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(t1);
        tick();
        nd = ndone;
        repeat (20) tick();
        chk("no second done", 128'(ndone), 128'(nd));
        chk("busy-start end", 128'({bus.busy, bus.blk_cnt}), 128'({1'b0, 16'd4}));
        // mid-operation asynchronous reset
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rnd(4'd4);
        nd = ndone;
        #2 rstn = 1'b0;
        #1 chk("async reset", 128'({bus.ready, bus.accept, bus.rndNo, bus.enbSB, bus.enbSR, bus.enbMC,
                                    bus.enbAR, bus.enbKS, bus.busy, bus.done, bus.blk_cnt}), 128'({1'b1, 28'h0}));
        repeat (2) tick();
        rstn = 1'b1;
        repeat (12) tick();
        chk("aborted block no done", 128'(ndone), 128'(nd));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(t1);
        tick();
        chk("post-reset cnt", 128'(bus.blk_cnt), 128'(1));
        // 2-bit counter wrap over five chained blocks
        do_reset();
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_done(t1);
            tick();
            if (k == 3) bus.start = 1'b0;
            chk($sformatf("wrap cnt %0d", k), 128'(bus2.blk_cnt), 128'(seq[k]));
        end
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
